// File: rtl/ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_stage
// Purpose  : EX-stage ALU with registered result and tags behind a valid/ready
//            handshake, plus a skid entry so in_ready never depends on out_ready.
// Revision : 1.0  initial release
// ============================================================================
module ex_alu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [RD_W-1:0] rd_in,
  input  logic            reg_write_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [RD_W-1:0] rd_out,
  output logic            reg_write_out,
  output logic            illegal_op
);

  localparam logic [2:0] C_OP_ADD  = 3'b000;
  localparam logic [2:0] C_OP_SUB  = 3'b001;
  localparam logic [2:0] C_OP_AND  = 3'b010;
  localparam logic [2:0] C_OP_OR   = 3'b011;
  localparam logic [2:0] C_OP_XOR  = 3'b100;
  localparam logic [2:0] C_OP_SLT  = 3'b101;
  localparam logic [2:0] C_OP_SLTU = 3'b110;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic [RD_W-1:0] rd;
    logic            rw;
    logic            ill;
  } entry_t;

  logic [XLEN-1:0] w_cap_res;
  logic            w_cap_ill;
  logic            w_accept;
  entry_t          w_cap_e;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;

  // Codes outside the legal set, including X/Z in simulation, fall to default.
  always_comb begin
    w_cap_res = '0;
    w_cap_ill = 1'b0;
    case (alu_ctrl)
      C_OP_ADD:  w_cap_res = src_a + src_b;
      C_OP_SUB:  w_cap_res = src_a - src_b;
      C_OP_AND:  w_cap_res = src_a & src_b;
      C_OP_OR:   w_cap_res = src_a | src_b;
      C_OP_XOR:  w_cap_res = src_a ^ src_b;
      C_OP_SLT:  w_cap_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      C_OP_SLTU: w_cap_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default:   w_cap_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_cap_e.res  = w_cap_res;
    w_cap_e.zero = (w_cap_res == '0);
    w_cap_e.rd   = rd_in;
    w_cap_e.rw   = reg_write_in & ~w_cap_ill;
    w_cap_e.ill  = w_cap_ill;
  end

  assign w_accept = in_valid & in_ready_q;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      // Skid can only be occupied while in_ready is low, so it never races the input.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        main_d       = w_cap_e;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_d       = w_cap_e;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign alu_result    = main_q.res;
  assign zero          = main_q.zero;
  assign rd_out        = main_q.rd;
  assign reg_write_out = main_q.rw;
  assign illegal_op    = main_q.ill;

endmodule
`default_nettype wire
